// File: rtl/fir_out_requant.sv
// Post-FIR requantizer: discards start-up samples, then decimates, rounds and
// saturates each kept sample to 16 bits and buffers it in a FWFT FIFO.
module fir_out_requant #(
  parameter int SHIFT  = 15,
  parameter int DECIM  = 4,
  parameter int WARMUP = 31,
  parameter int DEPTH  = 8
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic signed [31:0]         data_in,
  input  logic                       in_valid,
  input  logic                       clr_flags,
  output logic signed [15:0]         data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       sat_flag,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [32:0] RND =
    (SHIFT > 0) ? (33'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic [WW-1:0] WARM_MAX  = WW'(WARMUP);
  localparam logic [PW-1:0] PHASE_MAX = PW'(DECIM - 1);

  logic [WW-1:0]        warm_q, warm_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic signed [15:0]   s1_data_q, s1_data_d;
  logic                 s1_keep_q, s1_keep_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 sat_q, sat_d;
  logic                 ovf_q, ovf_d;
  logic signed [15:0]   mem_q [DEPTH];

  logic signed [32:0]   sum;
  logic signed [32:0]   shifted;
  logic signed [15:0]   req;
  logic                 clip;
  logic                 warm_done;
  logic                 keep_now;
  logic                 full;
  logic                 rd_en;
  logic                 wr_en;

  // Round half-up in 33 bits so the rounding add cannot wrap, then clip.
  always_comb begin
    sum     = {data_in[31], data_in} + RND;
    shifted = sum >>> SHIFT;
    clip    = 1'b0;
    req     = shifted[15:0];
    if (shifted > 33'sd32767) begin
      req  = 16'sh7FFF;
      clip = 1'b1;
    end else if (shifted < -33'sd32768) begin
      req  = 16'sh8000;
      clip = 1'b1;
    end
  end

  always_comb begin
    warm_done = (warm_q == WARM_MAX);
    warm_d    = warm_q;
    phase_d   = phase_q;
    keep_now  = 1'b0;
    if (in_valid) begin
      if (!warm_done) begin
        warm_d = warm_q + WW'(1);
      end else begin
        keep_now = (phase_q == '0);
        phase_d  = (phase_q == PHASE_MAX) ? '0 : phase_q + PW'(1);
      end
    end
    s1_keep_d = keep_now;
    s1_data_d = keep_now ? req : s1_data_q;
  end

  // A full FIFO still takes a write when the head leaves in the same cycle.
  always_comb begin
    out_valid = (level_q != '0);
    full      = (level_q == LW'(DEPTH));
    rd_en     = out_valid && out_ready;
    wr_en     = s1_keep_q && (!full || rd_en);
    wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q + LW'(wr_en) - LW'(rd_en);
    sat_d     = (sat_q && !clr_flags) || (keep_now && clip);
    ovf_d     = (ovf_q && !clr_flags) || (s1_keep_q && full && !rd_en);
    data_out  = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      warm_q    <= '0;
      phase_q   <= '0;
      s1_data_q <= '0;
      s1_keep_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      warm_q    <= warm_d;
      phase_q   <= phase_d;
      s1_data_q <= s1_data_d;
      s1_keep_q <= s1_keep_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s1_data_q;
    end
  end

  assign fifo_level = level_q;
  assign sat_flag   = sat_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Scoreboard bench for fir_out_requant: four instances, one per parameter set,
// driven one at a time; a negedge monitor pops expected samples on each transfer.
module tb_fir_out_requant;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic               reset;
  logic signed [31:0] din  [4];
  logic               iv   [4];
  logic               clr  [4];
  logic               ordy [4];
  logic signed [15:0] dout [4];
  logic               ov   [4];
  logic               satf [4];
  logic               ovf  [4];
  logic [3:0]         lvl  [4];

  typedef struct {
    int inst;
    int val;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // inst 0: warm-up / reset, inst 1: rounding / saturation,
  // inst 2: decimation, inst 3: backpressure
  fir_out_requant #(.SHIFT(15), .DECIM(1), .WARMUP(31), .DEPTH(8)) u_warm (
    .CLK(CLK), .reset(reset), .data_in(din[0]), .in_valid(iv[0]),
    .clr_flags(clr[0]), .data_out(dout[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .fifo_level(lvl[0]), .sat_flag(satf[0]),
    .overflow(ovf[0]));

  fir_out_requant #(.SHIFT(15), .DECIM(1), .WARMUP(0), .DEPTH(8)) u_rnd (
    .CLK(CLK), .reset(reset), .data_in(din[1]), .in_valid(iv[1]),
    .clr_flags(clr[1]), .data_out(dout[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .fifo_level(lvl[1]), .sat_flag(satf[1]),
    .overflow(ovf[1]));

  fir_out_requant #(.SHIFT(15), .DECIM(4), .WARMUP(0), .DEPTH(8)) u_dec (
    .CLK(CLK), .reset(reset), .data_in(din[2]), .in_valid(iv[2]),
    .clr_flags(clr[2]), .data_out(dout[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .fifo_level(lvl[2]), .sat_flag(satf[2]),
    .overflow(ovf[2]));

  fir_out_requant #(.SHIFT(0), .DECIM(1), .WARMUP(0), .DEPTH(8)) u_bp (
    .CLK(CLK), .reset(reset), .data_in(din[3]), .in_valid(iv[3]),
    .clr_flags(clr[3]), .data_out(dout[3]), .out_valid(ov[3]),
    .out_ready(ordy[3]), .fifo_level(lvl[3]), .sat_flag(satf[3]),
    .overflow(ovf[3]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int i, input int v);
    exp_t e;
    e.inst = i;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic send(input int i, input logic signed [31:0] x);
    din[i] = x;
    iv[i]  = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int i, input int n);
    iv[i] = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_clr(input int i);
    clr[i] = 1'b1;
    @(posedge CLK);
    #1;
    clr[i] = 1'b0;
  endtask

  // 31 samples discarded; sample 32 is kept and appears two edges later.
  task automatic warm_run(input int v);
    for (int k = 1; k <= 40; k++) begin
      send(0, v * 32768);
      if (k >= 32) push(0, v);
      chk($sformatf("warm_valid_k%0d", k), int'(ov[0]), int'(k >= 33));
    end
    idle(0, 4);
  endtask

  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (reset && ov[i] && ordy[i]) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output_inst%0d: got %0d expected none", i, dout[i]);
        end else begin
          mon_e = sb.pop_front();
          chk("out_instance", i, mon_e.inst);
          chk($sformatf("out_data_inst%0d", i), int'(dout[i]), mon_e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din[i]  = '0;
      iv[i]   = 1'b0;
      clr[i]  = 1'b0;
      ordy[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_valid_%0d", i), int'(ov[i]), 0);
      chk($sformatf("rst_data_%0d", i), int'(dout[i]), 0);
      chk($sformatf("rst_level_%0d", i), int'(lvl[i]), 0);
      chk($sformatf("rst_sat_%0d", i), int'(satf[i]), 0);
      chk($sformatf("rst_ovf_%0d", i), int'(ovf[i]), 0);
    end
    @(posedge CLK);
    #1;
    reset = 1'b1;

    warm_run(100);

    send(1, 16384);   push(1, 1);
    send(1, 16383);   push(1, 0);
    send(1, -16384);  push(1, 0);
    send(1, -16385);  push(1, -1);
    send(1, 49152);   push(1, 2);
    idle(1, 4);
    chk("round_sat_flag", int'(satf[1]), 0);

    send(1, 32'sh7FFFFFFF); push(1, 32767);
    send(1, 32'sh80000000); push(1, -32768);
    idle(1, 4);
    chk("sat_flag_set", int'(satf[1]), 1);
    chk("sat_no_overflow", int'(ovf[1]), 0);
    pulse_clr(1);
    chk("sat_flag_cleared", int'(satf[1]), 0);

    for (int n = 0; n < 16; n++) begin
      send(2, n * 32768);
      if (n % 4 == 0) push(2, n);
    end
    idle(2, 4);

    ordy[3] = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      send(3, n);
      if (n <= 8) push(3, n);
    end
    idle(3, 1);
    chk("bp_level_full", int'(lvl[3]), 8);
    chk("bp_overflow", int'(ovf[3]), 1);
    chk("bp_valid", int'(ov[3]), 1);
    chk("bp_head_stable", int'(dout[3]), 1);
    ordy[3] = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("bp_drain_level_%0d", j), int'(lvl[3]), 8 - j);
    end
    chk("bp_empty_valid", int'(ov[3]), 0);
    chk("bp_empty_data", int'(dout[3]), 0);
    chk("bp_overflow_sticky", int'(ovf[3]), 1);
    pulse_clr(3);
    chk("bp_overflow_cleared", int'(ovf[3]), 0);

    ordy[0] = 1'b0;
    for (int n = 0; n < 4; n++) send(0, 7 * 32768);
    send(0, 32'sh7FFFFFFF);
    idle(0, 1);
    chk("rst_pre_level", int'(lvl[0]), 5);
    chk("rst_pre_sat", int'(satf[0]), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_level", int'(lvl[0]), 0);
    chk("rst_mid_valid", int'(ov[0]), 0);
    chk("rst_mid_data", int'(dout[0]), 0);
    chk("rst_mid_sat", int'(satf[0]), 0);
    chk("rst_mid_ovf", int'(ovf[0]), 0);
    @(posedge CLK);
    #1;
    reset   = 1'b1;
    ordy[0] = 1'b1;
    warm_run(200);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
